stream_minmax: RTL
==================

STREAM_MINMAX -- requirements
Module: stream_minmax

Interface
REQ-001 SHALL have parameter N, default 32, sample width in bits (two's complement signed).
REQ-002 SHALL have parameter CNT_W, default 16, width of the sample counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous abort of the current frame.
REQ-006 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample.
REQ-008 SHALL have port in_data  input  N  signed sample.
REQ-009 SHALL have port in_last  input  1  marks the final sample of a frame.
REQ-010 SHALL have port out_valid  output  1  frame result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_min / out_max  output  N each  signed minimum / maximum of the frame.
REQ-013 SHALL have port out_count  output  CNT_W  samples accepted in the frame.
REQ-014 SHALL have port out_sat  output  1  out_count saturated.

Function
REQ-015 SHALL implement states IDLE (no sample yet), ACCUM (>=1 sample taken), DONE (result held).
REQ-016 SHALL accept a sample only on a cycle where in_valid and in_ready are both high.
REQ-017 SHALL drive in_ready high in IDLE and ACCUM, low in DONE and during reset.
REQ-018 SHALL, on a sample accepted in IDLE, load min = max = in_data, count = 1, and go to ACCUM (or DONE if in_last).
REQ-019 SHALL, on a sample accepted in ACCUM, replace min only if in_data < min (signed, strict) and max only if max < in_data (signed, strict).
REQ-020 SHALL compare as two's complement: e.g. 0xFFFFFFFF (-1) < 0x00000000, 0x80000000 is the most negative value.
REQ-021 SHALL saturate count at 2^CNT_W-1 and set out_sat once a further sample is accepted at that value.
REQ-022 SHALL, on acceptance with in_last high, enter DONE and assert out_valid on the next cycle (latency one cycle from last accept).
REQ-023 SHALL hold out_min, out_max, out_count, out_sat and any index outputs stable while out_valid is high and out_ready is low.
REQ-024 SHALL, on out_valid and out_ready both high, return to IDLE; in_ready is high on the following cycle.
REQ-025 SHALL, when clear is high, enter IDLE next cycle, drop out_valid, zero all result registers, and ignore any simultaneous input or output handshake.
REQ-026 SHALL accept a single-sample frame (first sample with in_last) yielding min = max = sample, count = 1.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, out_valid = 0, in_ready = 0, out_min = out_max = 0, out_count = 0, out_sat = 0, index outputs = 0, regardless of clk.
REQ-028 SHALL discard any partial frame when reset asserts mid-operation; in_ready rises on the first clock edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with STREAM_MINMAX_INDEX_EN defined, add outputs out_min_idx and out_max_idx (CNT_W each), the zero-based position of the first occurrence of min/max; ties keep the earlier index.
REQ-030 SHALL, without STREAM_MINMAX_INDEX_EN, omit those ports and their registers entirely; all other behaviour is identical.

Structure
REQ-031 SHALL take the state enum and default N/CNT_W constants from shared package minmax_pkg.
REQ-032 SHALL instantiate the existing signed less-than comparator module slt twice (sample-vs-min, max-vs-sample); no behavioural relational operators on the data path.

Verification
REQ-033 SHALL cover: frame {5, -3, 7, 0, last=-8} -> out_min=-8, out_max=7, out_count=5, out_valid one cycle after last accept.
REQ-034 SHALL cover: frame {0x7FFFFFFF, last=0x80000000} -> out_min=0x80000000, out_max=0x7FFFFFFF (no overflow misorder).
REQ-035 SHALL cover: result held with out_ready low 10 cycles -> outputs stable, in_ready low; then out_ready high -> IDLE, in_ready high next cycle.
REQ-036 SHALL cover: clear asserted after 3 samples, then frame {last=4} -> out_min=out_max=4, out_count=1.
REQ-037 SHALL cover: CNT_W=2, 5-sample frame -> out_count=3, out_sat=1; with STREAM_MINMAX_INDEX_EN, frame {2, 9, 9, last=2} -> out_min_idx=0, out_max_idx=1.
REQ-038 SHALL cover: rst_n pulsed low mid-frame -> all outputs zero asynchronously, next frame results unaffected by prior samples.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and default widths for the stream_minmax frame statistics block.
package minmax_pkg;

    localparam int MINMAX_N_DEF     = 32;
    localparam int MINMAX_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } minmax_state_t;

endpackage

// File: rtl/stream_minmax_slt.sv
// Signed less-than comparator (lt = a < b, two's complement) built on a widened subtract.
module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    logic [N:0] diff;

    // Sign-extending both operands by one bit means the difference never overflows,
    // so its top bit is the true sign of a - b.
    always_comb begin
        diff = {a[N-1], a} - {b[N-1], b};
        lt   = diff[N];
    end

endmodule

// File: rtl/stream_minmax.sv
// Frame min/max/count accumulator over a valid/ready sample stream.
// Define STREAM_MINMAX_INDEX_EN to add out_min_idx/out_max_idx (first-occurrence positions).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no sample of the current frame taken yet
// ST_ACCUM | at least one sample taken, waiting for in_last
// ST_DONE  | result held on the outputs until out_ready
module stream_minmax
    import minmax_pkg::*;
#(
    parameter int N     = MINMAX_N_DEF,
    parameter int CNT_W = MINMAX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_min,
    output logic [N-1:0]     out_max,
    output logic [CNT_W-1:0] out_count,
`ifdef STREAM_MINMAX_INDEX_EN
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
`endif
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    minmax_state_t    state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     min_q, min_d;
    logic [N-1:0]     max_q, max_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
`ifdef STREAM_MINMAX_INDEX_EN
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;
`endif

    logic accept;
    logic out_fire;
    logic new_min;
    logic new_max;

    slt #(.N(N)) u_slt_min (
        .a  (in_data),
        .b  (min_q),
        .lt (new_min)
    );

    slt #(.N(N)) u_slt_max (
        .a  (max_q),
        .b  (in_data),
        .lt (new_max)
    );

    assign accept   = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        sat_d   = sat_q;
`ifdef STREAM_MINMAX_INDEX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif

        if (clear) begin
            state_d = ST_IDLE;
            min_d   = '0;
            max_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
`ifdef STREAM_MINMAX_INDEX_EN
            min_idx_d = '0;
            max_idx_d = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        min_d   = in_data;
                        max_d   = in_data;
                        count_d = CNT_ONE;
                        sat_d   = 1'b0;
`ifdef STREAM_MINMAX_INDEX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                        state_d = in_last ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        // Strict compares keep the earlier sample on ties.
                        if (new_min) begin
                            min_d = in_data;
`ifdef STREAM_MINMAX_INDEX_EN
                            min_idx_d = count_q;
`endif
                        end
                        if (new_max) begin
                            max_d = in_data;
`ifdef STREAM_MINMAX_INDEX_EN
                            max_idx_d = count_q;
`endif
                        end
                        if (count_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                        if (in_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_fire) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_DONE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
`ifdef STREAM_MINMAX_INDEX_EN
            min_idx_q   <= '0;
            max_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            min_q       <= min_d;
            max_q       <= max_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
`ifdef STREAM_MINMAX_INDEX_EN
            min_idx_q   <= min_idx_d;
            max_idx_q   <= max_idx_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;
    assign out_sat   = sat_q;
`ifdef STREAM_MINMAX_INDEX_EN
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
`endif

endmodule
